alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for the 8-bit accumulator ALU. Accepts queued ALU commands over

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/seq_cmd_fifo.sv | 77 +++++++
 rtl/alu_cmd_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: FSM states, opcodes,
// accumulator input-select codes and the opcode-to-output-select decoder.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_OFF       = 2'b00,
    S_READY     = 2'b01,
    S_RUN       = 2'b10,
    S_RUN_ERROR = 2'b11
  } seq_state_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [2:0] SEL_HOLD    = 3'b000;

  // AND maps to the MSB, MUL to the LSB; CLR selects no output.
  function automatic logic [6:0] op_to_onehot(input logic [2:0] op);
    logic [6:0] oh;
    oh = '0;
    if (op != OP_CLR) begin
      oh[3'd6 - op] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic op_can_overflow(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command queue holding {op, load, a, b}; first-word fall-through
// read so the sequencer can pop and register the head in the same cycle.
module seq_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [2:0]       wr_op,
  input  logic             wr_load,
  input  logic [WIDTH-1:0] wr_a,
  input  logic [WIDTH-1:0] wr_b,
  input  logic             pop,
  output logic [2:0]       rd_op,
  output logic             rd_load,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  output logic             full,
  output logic             empty
);

  localparam int ENTRY_W = 2 * WIDTH + 4;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = FIFO_DEPTH[AW:0];

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;
  logic [ENTRY_W-1:0] head;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = mem_q[rd_ptr_q];
  assign {rd_op, rd_load, rd_a, rd_b} = head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {wr_op, wr_load, wr_a, wr_b};
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command stage for the accumulator ALU: queues commands, issues one at a time,
// waits the ALU latency, and hands back result/error over valid/ready.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       alu_in_sel,
  output logic [6:0]       alu_out_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_error,
  output logic [1:0]       state
);

  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] LAT_C = ALU_LAT[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE = 1;

  seq_state_e       state_q, state_d;
  logic [2:0]       in_sel_q, in_sel_d;
  logic [6:0]       out_sel_q, out_sel_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_error_q, res_error_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [2:0]       fifo_op;
  logic             fifo_load;
  logic [WIDTH-1:0] fifo_a, fifo_b;
  logic             err_now;

  // Held low through reset so nothing can be queued before the flush completes.
  assign cmd_ready = rst_n && !fifo_full;

  seq_cmd_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid && cmd_ready),
    .wr_op   (cmd_op),
    .wr_load (cmd_load),
    .wr_a    (cmd_a),
    .wr_b    (cmd_b),
    .pop     (fifo_pop),
    .rd_op   (fifo_op),
    .rd_load (fifo_load),
    .rd_a    (fifo_a),
    .rd_b    (fifo_b),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign err_now = alu_overflow && op_can_overflow(op_q);

  always_comb begin
    state_d     = state_q;
    in_sel_d    = in_sel_q;
    out_sel_d   = out_sel_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    fifo_pop    = 1'b0;

    case (state_q)
      // Present the reset select for exactly one cycle, then go idle.
      S_OFF: begin
        if (in_sel_q == SEL_RESET) begin
          in_sel_d = SEL_HOLD;
          state_d  = S_READY;
        end else begin
          in_sel_d = SEL_RESET;
        end
      end
      S_READY: begin
        in_sel_d = SEL_HOLD;
        if (!res_valid_q && !fifo_empty) begin
          fifo_pop  = 1'b1;
          op_d      = fifo_op;
          out_sel_d = op_to_onehot(fifo_op);
          num1_d    = fifo_a;
          num2_d    = fifo_b;
          if (fifo_op == OP_CLR)  in_sel_d = SEL_RESET;
          else if (fifo_load)     in_sel_d = SEL_LOAD;
          else                    in_sel_d = SEL_PERSIST;
          cnt_d     = LAT_C;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        in_sel_d = SEL_HOLD;
        if (res_valid_q) begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = S_READY;
          end
        end else if (cnt_q == '0) begin
          res_valid_d = 1'b1;
          if (op_q == OP_CLR) begin
            res_data_d  = '0;
            res_error_d = 1'b0;
          end else begin
            res_data_d  = alu_result;
            res_error_d = err_now;
          end
          if (op_q != OP_CLR && err_now) state_d = S_RUN_ERROR;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RUN_ERROR: begin
        in_sel_d = SEL_HOLD;
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_error_d = 1'b0;
          in_sel_d    = SEL_RESET;
          state_d     = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      in_sel_q    <= SEL_HOLD;
      out_sel_q   <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_sel_q    <= in_sel_d;
      out_sel_q   <= out_sel_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
    end
  end

  assign alu_in_sel  = in_sel_q;
  assign alu_out_sel = out_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_error   = res_error_q;
  assign state       = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a 2-cycle accumulator ALU stub.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_load;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_num1, alu_num2;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_error;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(8), .FIFO_DEPTH(4), .ALU_LAT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_load     (cmd_load),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_in_sel   (alu_in_sel),
    .alu_out_sel  (alu_out_sel),
    .alu_num1     (alu_num1),
    .alu_num2     (alu_num2),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_error    (res_error),
    .state        (state)
  );

  // ALU stub: accumulator updated on any non-hold select, result two cycles later.
  logic [7:0]  acc = 8'h00, st1_r = 8'h00, st2_r = 8'h00;
  logic        st1_o = 1'b0, st2_o = 1'b0;
  logic [7:0]  calc_x, calc_r;
  logic        calc_o;
  logic [15:0] prod;

  always_comb begin
    calc_x = 8'h00;
    calc_r = 8'h00;
    calc_o = 1'b0;
    prod   = 16'h0000;
    if (alu_in_sel == 3'b010)      calc_x = alu_num1;
    else if (alu_in_sel == 3'b100) calc_x = acc;
    if (alu_in_sel != 3'b001) begin
      case (alu_out_sel)
        7'b1000000: calc_r = calc_x & alu_num2;
        7'b0100000: calc_r = calc_x | alu_num2;
        7'b0010000: calc_r = ~calc_x;
        7'b0001000: calc_r = calc_x ^ alu_num2;
        7'b0000100: {calc_o, calc_r} = {1'b0, calc_x} + {1'b0, alu_num2};
        7'b0000010: begin calc_r = calc_x - alu_num2; calc_o = (calc_x < alu_num2); end
        7'b0000001: begin
          prod   = {8'h00, calc_x} * {8'h00, alu_num2};
          calc_r = prod[7:0];
          calc_o = |prod[15:8];
        end
        default: calc_r = 8'h00;
      endcase
    end
  end

  always @(posedge clk) begin
    if (alu_in_sel != 3'b000) begin
      acc   <= calc_r;
      st1_r <= calc_r;
      st1_o <= calc_o;
    end
    st2_r <= st1_r;
    st2_o <= st1_o;
  end

  assign alu_result   = st2_r;
  assign alu_overflow = st2_o;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic ld, input logic [7:0] a,
                      input logic [7:0] b, output bit ok);
    bit acc_now;
    ok        = 1'b0;
    cmd_op    = op;
    cmd_load  = ld;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc_now = cmd_ready;
      step();
      if (acc_now) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL rst_state: got %b want 00", state); end
    total++; if (alu_in_sel !== 3'b000) begin bad++; $display("FAIL rst_in_sel: got %b want 000", alu_in_sel); end
    total++; if (alu_out_sel !== 7'b0) begin bad++; $display("FAIL rst_out_sel: got %b want 0000000", alu_out_sel); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    rst_n = 1'b1;
    step();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL off_state: got %b want 00", state); end
    total++; if (alu_in_sel !== 3'b001) begin bad++; $display("FAIL off_in_sel: got %b want 001", alu_in_sel); end
    step();
    total++; if (state !== 2'b01) begin bad++; $display("FAIL ready_state: got %b want 01", state); end
    total++; if (alu_in_sel !== 3'b000) begin bad++; $display("FAIL ready_in_sel: got %b want 000", alu_in_sel); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_cmd_ready: got %b want 1", cmd_ready); end
    $display("reset: state=%b in_sel=%b cmd_ready=%b", state, alu_in_sel, cmd_ready);
  endtask

  task automatic test_load_add();
    bit ok;
    push(3'd4, 1'b1, 8'h05, 8'h03, ok);
    total++; if (!ok) begin bad++; $display("FAIL add_push: accepted got 0 want 1"); end
    step();
    total++; if (alu_in_sel !== 3'b010) begin bad++; $display("FAIL add_issue_in_sel: got %b want 010", alu_in_sel); end
    total++; if (alu_out_sel !== 7'b0000100) begin bad++; $display("FAIL add_out_sel: got %b want 0000100", alu_out_sel); end
    total++; if ({alu_num1, alu_num2} !== 16'h0503) begin bad++; $display("FAIL add_nums: got %h want 0503", {alu_num1, alu_num2}); end
    total++; if (state !== 2'b10) begin bad++; $display("FAIL add_state: got %b want 10", state); end
    step();
    total++; if (alu_in_sel !== 3'b000) begin bad++; $display("FAIL add_hold_in_sel: got %b want 000", alu_in_sel); end
    total++; if (alu_out_sel !== 7'b0000100) begin bad++; $display("FAIL add_hold_out_sel: got %b want 0000100", alu_out_sel); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid: got %b want 0", res_valid); end
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL add_latency: res_valid got %b want 1", res_valid); end
    total++; if (res_data !== 8'h08) begin bad++; $display("FAIL add_data: got %h want 08", res_data); end
    total++; if (res_error !== 1'b0) begin bad++; $display("FAIL add_error: got %b want 0", res_error); end
    accept();
    total++; if (res_valid !== 1'b0 || state !== 2'b01) begin bad++; $display("FAIL add_accept: valid/state got %b/%b want 0/01", res_valid, state); end
    $display("load add 05+03: res_data=%h res_error=%b", 8'h08, 1'b0);
  endtask

  task automatic test_persist_sub();
    bit ok;
    push(3'd5, 1'b0, 8'hEE, 8'h02, ok);
    total++; if (!ok) begin bad++; $display("FAIL sub_push: accepted got 0 want 1"); end
    step();
    total++; if (alu_in_sel !== 3'b100) begin bad++; $display("FAIL sub_in_sel: got %b want 100", alu_in_sel); end
    total++; if (alu_out_sel !== 7'b0000010) begin bad++; $display("FAIL sub_out_sel: got %b want 0000010", alu_out_sel); end
    wait_res(ok);
    total++; if (!ok) begin bad++; $display("FAIL sub_timeout: res_valid got 0 want 1"); end
    total++; if (res_data !== 8'h06) begin bad++; $display("FAIL sub_data: got %h want 06", res_data); end
    total++; if (res_error !== 1'b0) begin bad++; $display("FAIL sub_error: got %b want 0", res_error); end
    accept();
    $display("persist sub 08-02: res_data=%h", res_data);
  endtask

  task automatic test_clr();
    bit ok;
    push(3'd7, 1'b0, 8'h77, 8'h88, ok);
    total++; if (!ok) begin bad++; $display("FAIL clr_push: accepted got 0 want 1"); end
    step();
    total++; if ({alu_in_sel, alu_out_sel} !== 10'b001_0000000) begin bad++; $display("FAIL clr_sel: got %b want 0010000000", {alu_in_sel, alu_out_sel}); end
    wait_res(ok);
    total++; if (!ok) begin bad++; $display("FAIL clr_timeout: res_valid got 0 want 1"); end
    total++; if ({res_data, res_error} !== 9'h000) begin bad++; $display("FAIL clr_result: got %h/%b want 00/0", res_data, res_error); end
    accept();
    $display("clr: res_data=%h res_error=%b", 8'h00, 1'b0);
  endtask

  task automatic test_overflow();
    bit ok;
    push(3'd6, 1'b1, 8'h20, 8'h10, ok);
    total++; if (!ok) begin bad++; $display("FAIL mul_push: accepted got 0 want 1"); end
    wait_res(ok);
    total++; if (!ok) begin bad++; $display("FAIL mul_timeout: res_valid got 0 want 1"); end
    total++; if (res_error !== 1'b1) begin bad++; $display("FAIL mul_error: got %b want 1", res_error); end
    total++; if (res_data !== 8'h00) begin bad++; $display("FAIL mul_data: got %h want 00", res_data); end
    total++; if (state !== 2'b11) begin bad++; $display("FAIL mul_state: got %b want 11", state); end
    step();
    total++; if ({res_valid, res_error, state} !== 4'b1111) begin bad++; $display("FAIL mul_hold: valid/err/state got %b%b%b want 1111", res_valid, res_error, state); end
    accept();
    total++; if (state !== 2'b00 || alu_in_sel !== 3'b001) begin bad++; $display("FAIL err_exit: state/in_sel got %b/%b want 00/001", state, alu_in_sel); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL err_exit_valid: got %b want 0", res_valid); end
    step();
    total++; if (state !== 2'b01 || alu_in_sel !== 3'b000) begin bad++; $display("FAIL err_ready: state/in_sel got %b/%b want 01/000", state, alu_in_sel); end
    $display("mul 20*10 overflow: res_error=1 then accumulator reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops  [6] = '{3'd4, 3'd3, 3'd0, 3'd2, 3'd1, 3'd5};
    logic       lds  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] as   [6] = '{8'h10, 8'h0F, 8'h00, 8'h55, 8'h00, 8'h09};
    logic [7:0] bs   [6] = '{8'h01, 8'hFF, 8'h3C, 8'h00, 8'h01, 8'h04};
    logic [7:0] exps [6] = '{8'h11, 8'hF0, 8'h30, 8'hAA, 8'hAB, 8'h05};
    bit ok;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(ops[i], lds[i], as[i], bs[i], ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_push%0d: accepted got 0 want 1", i); end
    end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: cmd_ready got %b want 0", cmd_ready); end
    step();
    step();
    step();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_no_pop_pending: cmd_ready got %b want 0", cmd_ready); end
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        push(ops[5], lds[5], as[5], bs[5], ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_push5: accepted got 0 want 1"); end
      end
      wait_res(ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout%0d: res_valid got 0 want 1", i); end
      total++; if (res_data !== exps[i] || res_error !== 1'b0) begin
        bad++; $display("FAIL b2b_res%0d: got %h/%b want %h/0", i, res_data, res_error, exps[i]);
      end
      $display("b2b result %0d: res_data=%h", i, res_data);
      accept();
    end
  endtask

  task automatic test_reset_inflight();
    bit ok;
    push(3'd4, 1'b1, 8'h01, 8'h01, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_push0: accepted got 0 want 1"); end
    push(3'd4, 1'b1, 8'h02, 8'h02, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_push1: accepted got 0 want 1"); end
    step();
    rst_n = 1'b0;
    step();
    total++; if ({res_valid, state, alu_in_sel} !== 6'b0_00_000) begin bad++; $display("FAIL abort_rst: valid/state/in_sel got %b/%b/%b want 0/00/000", res_valid, state, alu_in_sel); end
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (res_valid !== 1'b0) ok = 1'b1;
    end
    total++; if (ok) begin bad++; $display("FAIL abort_stale: res_valid got 1 want 0"); end
    total++; if (state !== 2'b01 || cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_idle: state/cmd_ready got %b/%b want 01/1", state, cmd_ready); end
    $display("reset during run: no stale result, state=%b", state);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_load  = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    res_ready = 1'b0;
    #1;
    test_reset();
    test_load_add();
    test_persist_sub();
    test_clr();
    test_overflow();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time got limit want finish");
    $fatal(1);
  end

endmodule
